// File: rtl/de_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg -- Decode-to-Execute pipeline register with stall/flush control
// and saturating stall/bubble performance counters.
//
// Parameters
//   DATA_W     width of operand, immediate and PC fields
//   REG_AW     width of register-address fields
//   CNT_W      width of each performance counter
//   RD0_SQUASH when set, a write targeting x0 is dropped at capture
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   stall, flush        hold / bubble the E stage (flush wins over stall)
//   *D inputs           decode-stage instruction fields
//   *E outputs          registered execute-stage copies of the D fields
//   StallCnt, BubbleCnt saturating counts of stall cycles / inserted bubbles
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module de_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter bit RD0_SQUASH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ValidD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic [3:0]        ALUCtrlD,
    input  logic              ALUSrcAD,
    input  logic              ALUSrcBD,
    input  logic [DATA_W-1:0] rs1D,
    input  logic [DATA_W-1:0] rs2D,
    input  logic [DATA_W-1:0] ImmExtD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] inc_PCD,
    input  logic [2:0]        funct3D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [REG_AW-1:0] Rs1AddrD,
    input  logic [REG_AW-1:0] Rs2AddrD,
    output logic              ValidE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic [1:0]        ResultSrcE,
    output logic [3:0]        ALUCtrlE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic [DATA_W-1:0] rs1E,
    output logic [DATA_W-1:0] rs2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] inc_PCE,
    output logic [2:0]        funct3E,
    output logic [REG_AW-1:0] RdE,
    output logic [REG_AW-1:0] Rs1AddrE,
    output logic [REG_AW-1:0] Rs2AddrE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  BubbleCnt
);

    typedef struct packed {
        logic              valid;
        logic              jump;
        logic              branch;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic [3:0]        alu_ctrl;
        logic              alu_src_a;
        logic              alu_src_b;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inc_pc;
        logic [2:0]        funct3;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
    } e_stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    e_stage_t         stage_d, stage_q, capt;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             rd_is_x0;

    // Decode-stage view after side-effect gating.
    always_comb begin
        rd_is_x0       = (RdD == '0);
        capt.valid      = ValidD;
        // Side-effect enables only survive for a valid instruction.
        capt.jump       = JumpD & ValidD;
        capt.branch     = BranchD & ValidD;
        capt.mem_write  = MemWriteD & ValidD;
        capt.reg_write  = RegWriteD & ValidD & ~(RD0_SQUASH & rd_is_x0);
        capt.result_src = ResultSrcD;
        capt.alu_ctrl   = ALUCtrlD;
        capt.alu_src_a  = ALUSrcAD;
        capt.alu_src_b  = ALUSrcBD;
        capt.rs1        = rs1D;
        capt.rs2        = rs2D;
        capt.imm_ext    = ImmExtD;
        capt.pc         = PCD;
        capt.inc_pc     = inc_PCD;
        capt.funct3     = funct3D;
        capt.rd         = RdD;
        capt.rs1_addr   = Rs1AddrD;
        capt.rs2_addr   = Rs2AddrD;
    end

    // flush > stall > capture; reset is applied in the register process.
    always_comb begin
        stage_d      = stage_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stage_d = '0;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (stall) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stage_d = capt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidE     = stage_q.valid;
    assign JumpE      = stage_q.jump;
    assign BranchE    = stage_q.branch;
    assign RegWriteE  = stage_q.reg_write;
    assign MemWriteE  = stage_q.mem_write;
    assign ResultSrcE = stage_q.result_src;
    assign ALUCtrlE   = stage_q.alu_ctrl;
    assign ALUSrcAE   = stage_q.alu_src_a;
    assign ALUSrcBE   = stage_q.alu_src_b;
    assign rs1E       = stage_q.rs1;
    assign rs2E       = stage_q.rs2;
    assign ImmExtE    = stage_q.imm_ext;
    assign PCE        = stage_q.pc;
    assign inc_PCE    = stage_q.inc_pc;
    assign funct3E    = stage_q.funct3;
    assign RdE        = stage_q.rd;
    assign Rs1AddrE   = stage_q.rs1_addr;
    assign Rs2AddrE   = stage_q.rs2_addr;
    assign StallCnt   = stall_cnt_q;
    assign BubbleCnt  = bubble_cnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: two instances share the D-side stimulus.
//   dut_a: defaults (RD0_SQUASH=1, CNT_W=16)
//   dut_b: RD0_SQUASH=0, CNT_W=4 (squash-off and saturation cases)
module tb_de_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        jump;
        logic        branch;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [3:0]  alu_ctrl;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] inc_pc;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst, stall, flush;
    bundle_t din;
    bundle_t obs_a, obs_b, exp_a, exp_b;
    int      sc_a, bc_a, sc_b, bc_b;
    int      vectors = 0;
    int      miscompares = 0;

    logic        ValidE_a, JumpE_a, BranchE_a, RegWriteE_a, MemWriteE_a, ALUSrcAE_a, ALUSrcBE_a;
    logic [1:0]  ResultSrcE_a;
    logic [3:0]  ALUCtrlE_a;
    logic [31:0] rs1E_a, rs2E_a, ImmExtE_a, PCE_a, inc_PCE_a;
    logic [2:0]  funct3E_a;
    logic [4:0]  RdE_a, Rs1AddrE_a, Rs2AddrE_a;
    logic [15:0] StallCnt_a, BubbleCnt_a;

    logic        ValidE_b, JumpE_b, BranchE_b, RegWriteE_b, MemWriteE_b, ALUSrcAE_b, ALUSrcBE_b;
    logic [1:0]  ResultSrcE_b;
    logic [3:0]  ALUCtrlE_b;
    logic [31:0] rs1E_b, rs2E_b, ImmExtE_b, PCE_b, inc_PCE_b;
    logic [2:0]  funct3E_b;
    logic [4:0]  RdE_b, Rs1AddrE_b, Rs2AddrE_b;
    logic [3:0]  StallCnt_b, BubbleCnt_b;

    always #5 clk = ~clk;

    de_pipe_reg dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ValidD(din.valid), .JumpD(din.jump), .BranchD(din.branch),
        .RegWriteD(din.reg_write), .MemWriteD(din.mem_write),
        .ResultSrcD(din.result_src), .ALUCtrlD(din.alu_ctrl),
        .ALUSrcAD(din.alu_src_a), .ALUSrcBD(din.alu_src_b),
        .rs1D(din.rs1), .rs2D(din.rs2), .ImmExtD(din.imm),
        .PCD(din.pc), .inc_PCD(din.inc_pc), .funct3D(din.funct3),
        .RdD(din.rd), .Rs1AddrD(din.rs1a), .Rs2AddrD(din.rs2a),
        .ValidE(ValidE_a), .JumpE(JumpE_a), .BranchE(BranchE_a),
        .RegWriteE(RegWriteE_a), .MemWriteE(MemWriteE_a),
        .ResultSrcE(ResultSrcE_a), .ALUCtrlE(ALUCtrlE_a),
        .ALUSrcAE(ALUSrcAE_a), .ALUSrcBE(ALUSrcBE_a),
        .rs1E(rs1E_a), .rs2E(rs2E_a), .ImmExtE(ImmExtE_a),
        .PCE(PCE_a), .inc_PCE(inc_PCE_a), .funct3E(funct3E_a),
        .RdE(RdE_a), .Rs1AddrE(Rs1AddrE_a), .Rs2AddrE(Rs2AddrE_a),
        .StallCnt(StallCnt_a), .BubbleCnt(BubbleCnt_a)
    );

    de_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4), .RD0_SQUASH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ValidD(din.valid), .JumpD(din.jump), .BranchD(din.branch),
        .RegWriteD(din.reg_write), .MemWriteD(din.mem_write),
        .ResultSrcD(din.result_src), .ALUCtrlD(din.alu_ctrl),
        .ALUSrcAD(din.alu_src_a), .ALUSrcBD(din.alu_src_b),
        .rs1D(din.rs1), .rs2D(din.rs2), .ImmExtD(din.imm),
        .PCD(din.pc), .inc_PCD(din.inc_pc), .funct3D(din.funct3),
        .RdD(din.rd), .Rs1AddrD(din.rs1a), .Rs2AddrD(din.rs2a),
        .ValidE(ValidE_b), .JumpE(JumpE_b), .BranchE(BranchE_b),
        .RegWriteE(RegWriteE_b), .MemWriteE(MemWriteE_b),
        .ResultSrcE(ResultSrcE_b), .ALUCtrlE(ALUCtrlE_b),
        .ALUSrcAE(ALUSrcAE_b), .ALUSrcBE(ALUSrcBE_b),
        .rs1E(rs1E_b), .rs2E(rs2E_b), .ImmExtE(ImmExtE_b),
        .PCE(PCE_b), .inc_PCE(inc_PCE_b), .funct3E(funct3E_b),
        .RdE(RdE_b), .Rs1AddrE(Rs1AddrE_b), .Rs2AddrE(Rs2AddrE_b),
        .StallCnt(StallCnt_b), .BubbleCnt(BubbleCnt_b)
    );

    assign obs_a = {ValidE_a, JumpE_a, BranchE_a, RegWriteE_a, MemWriteE_a, ResultSrcE_a,
                    ALUCtrlE_a, ALUSrcAE_a, ALUSrcBE_a, rs1E_a, rs2E_a, ImmExtE_a, PCE_a,
                    inc_PCE_a, funct3E_a, RdE_a, Rs1AddrE_a, Rs2AddrE_a};
    assign obs_b = {ValidE_b, JumpE_b, BranchE_b, RegWriteE_b, MemWriteE_b, ResultSrcE_b,
                    ALUCtrlE_b, ALUSrcAE_b, ALUSrcBE_b, rs1E_b, rs2E_b, ImmExtE_b, PCE_b,
                    inc_PCE_b, funct3E_b, RdE_b, Rs1AddrE_b, Rs2AddrE_b};

    // What an E stage should hold after taking instruction d.
    function automatic bundle_t expected_capture(bundle_t d, bit squash_x0);
        bundle_t e = d;
        if (!d.valid) begin
            e.jump      = 1'b0;
            e.branch    = 1'b0;
            e.reg_write = 1'b0;
            e.mem_write = 1'b0;
        end
        if (squash_x0 && d.rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    function automatic int sat_inc(int v, int cnt_w);
        return (v + 1 > (1 << cnt_w) - 1) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [190:0] obs, input logic [190:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a_stage"}, obs_a, exp_a);
        chk({tag, "/a_stallcnt"}, 191'(StallCnt_a), 191'(sc_a));
        chk({tag, "/a_bubblecnt"}, 191'(BubbleCnt_a), 191'(bc_a));
        chk({tag, "/b_stage"}, obs_b, exp_b);
        chk({tag, "/b_stallcnt"}, 191'(StallCnt_b), 191'(sc_b));
        chk({tag, "/b_bubblecnt"}, 191'(BubbleCnt_b), 191'(bc_b));
    endtask

    // Apply one clock with the given controls, advance the model, then check.
    task automatic step(input logic r, input logic s, input logic f, input string tag);
        rst   = r;
        stall = s;
        flush = f;
        @(posedge clk);
        if (r) begin
            exp_a = '0; exp_b = '0;
            sc_a = 0; bc_a = 0; sc_b = 0; bc_b = 0;
        end else if (f) begin
            exp_a = '0; exp_b = '0;
            bc_a = sat_inc(bc_a, 16);
            bc_b = sat_inc(bc_b, 4);
        end else if (s) begin
            sc_a = sat_inc(sc_a, 16);
            sc_b = sat_inc(sc_b, 4);
        end else begin
            exp_a = expected_capture(din, 1'b1);
            exp_b = expected_capture(din, 1'b0);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic rand_din();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        din = r[190:0];
        if ($urandom_range(0, 3) == 0) din.rd = 5'd0;
        if ($urandom_range(0, 3) != 0) din.valid = 1'b1;
    endtask

    initial begin
        int hold_sc;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        din = '0;
        exp_a = '0; exp_b = '0;
        sc_a = 0; bc_a = 0; sc_b = 0; bc_b = 0;
        @(negedge clk);

        // Reset state, with stall and flush also asserted.
        step(1'b1, 1'b1, 1'b1, "reset");

        // Basic capture.
        din = '0;
        din.valid = 1'b1; din.reg_write = 1'b1; din.rd = 5'd5; din.rs1 = 32'h12345678;
        step(1'b0, 1'b0, 1'b0, "capture");
        chk("capture_valid", 191'(ValidE_a), 191'(1));
        chk("capture_regwrite", 191'(RegWriteE_a), 191'(1));
        chk("capture_rd", 191'(RdE_a), 191'(5));
        chk("capture_rs1", 191'(rs1E_a), 191'(32'h12345678));

        // Stall for three cycles while D changes.
        for (int i = 0; i < 3; i++) begin
            rand_din();
            step(1'b0, 1'b1, 1'b0, "stall3");
        end
        chk("stall3_rs1_frozen", 191'(rs1E_a), 191'(32'h12345678));
        chk("stall3_count", 191'(StallCnt_a), 191'(3));

        // Flush together with stall and a memory write.
        rand_din();
        din.valid = 1'b1; din.mem_write = 1'b1;
        step(1'b0, 1'b1, 1'b1, "flush_stall");
        chk("flush_memwrite", 191'(MemWriteE_a), 191'(0));
        chk("flush_valid", 191'(ValidE_a), 191'(0));
        chk("flush_bubblecnt", 191'(BubbleCnt_a), 191'(1));
        chk("flush_stallcnt", 191'(StallCnt_a), 191'(3));

        // Write to x0: squashed on dut_a, kept on dut_b.
        rand_din();
        din.valid = 1'b1; din.reg_write = 1'b1; din.rd = 5'd0;
        step(1'b0, 1'b0, 1'b0, "x0");
        chk("x0_squash_on", 191'(RegWriteE_a), 191'(0));
        chk("x0_squash_off", 191'(RegWriteE_b), 191'(1));

        // Invalid instruction never enables side effects.
        din.valid = 1'b0; din.jump = 1'b1; din.branch = 1'b1;
        din.reg_write = 1'b1; din.mem_write = 1'b1; din.rd = 5'd7;
        step(1'b0, 1'b0, 1'b0, "invalid");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int p;
            rand_din();
            p = $urandom_range(0, 99);
            step(p < 2, (p % 5) == 1, (p % 7) == 3, "random");
        end

        // Reset in the middle of a stall, then capture resumes.
        for (int i = 0; i < 2; i++) begin
            rand_din();
            step(1'b0, 1'b1, 1'b0, "mid_stall");
        end
        step(1'b1, 1'b1, 1'b0, "mid_stall_rst");
        rand_din();
        step(1'b0, 1'b0, 1'b0, "resume");

        // Counter saturation on the 4-bit instance, then reset.
        step(1'b1, 1'b0, 1'b0, "sat_rst");
        for (int i = 0; i < 20; i++) begin
            rand_din();
            step(1'b0, 1'b1, 1'b0, "stall_sat");
        end
        chk("stall_sat_15", 191'(StallCnt_b), 191'(15));
        hold_sc = 20;
        chk("stall_20_wide", 191'(StallCnt_a), 191'(hold_sc));
        for (int i = 0; i < 20; i++) begin
            rand_din();
            step(1'b0, 1'b0, 1'b1, "bubble_sat");
        end
        chk("bubble_sat_15", 191'(BubbleCnt_b), 191'(15));
        rand_din();
        step(1'b0, 1'b0, 1'b0, "post_sat_capture");
        step(1'b1, 1'b0, 1'b0, "final_rst");
        chk("final_rst_stage_b", obs_b, 191'(0));
        chk("final_rst_stall_b", 191'(StallCnt_b), 191'(0));
        chk("final_rst_bubble_b", 191'(BubbleCnt_b), 191'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
